wb_commit_arbiter: RTL and testbench

- Merges the two write-back ways of the dual-issue pipeline onto the integer register-file write port.
- Buffers each way's write-back requests in a small FIFO.
- Retires them strictly in program order using the 2-bit pID tag carried by each way.
- Sits between the per-way write-back stages and the register file.
- Provides back-pressure and flags ordering faults.

---
 rtl/wb_commit_arbiter_pkg.sv | 11 +
 rtl/wb_commit_arbiter_if.sv | 11 +
 rtl/wb_commit_arbiter_fifo.sv | 34 +++
 rtl/wb_commit_arbiter.sv | 112 +++++++++++
 tb/tb_wb_commit_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_commit_arbiter_pkg.sv
// b8_wb_pkg: shared types and defaults for the write-back commit arbiter.
package b8_wb_pkg;
  localparam int PID_W = 2;
  localparam int STALL_LIMIT_DEF = 15;
  typedef struct packed {
    logic             we;
    logic [4:0]       addr;
    logic [63:0]      data;
    logic [PID_W-1:0] pid;
  } wb_entry_t;
endpackage

// File: rtl/wb_commit_arbiter_if.sv
// wb_commit_arbiter_if: one write-back way's request channel into the arbiter.
interface wb_commit_arbiter_if;
  logic                       valid;
  logic                       ready;
  logic                       we;
  logic [4:0]                 addr;
  logic [63:0]                data;
  logic [b8_wb_pkg::PID_W-1:0] pid;
  modport master(output valid, we, addr, data, pid, input ready);
  modport slave(input valid, we, addr, data, pid, output ready);
endinterface

// File: rtl/wb_commit_arbiter_fifo.sv
// wb_fifo: DEPTH-entry FIFO of write-back entries with flush and head peek.
module wb_fifo import b8_wb_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t mem [DEPTH];
  logic [AW:0] wr, rd;
  assign empty = wr == rd;
  assign full = (wr[AW-1:0] == rd[AW-1:0]) && (wr[AW] != rd[AW]);
  assign head = mem[rd[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr <= '0;
      rd <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push && !full) wr <= wr + 1'b1;
      if (pop && !empty) rd <= rd + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full && !flush) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/wb_commit_arbiter.sv
// wb_commit_arbiter: retires two write-back ways onto one register-file port in pID order.
// Define WB_DUAL_COMMIT_EN for a second write port retiring two adjacent pIDs per cycle.
module wb_commit_arbiter import b8_wb_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int STALL_LIMIT = STALL_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [PID_W-1:0]    flush_pid,
  wb_commit_arbiter_if.slave  way0,
  wb_commit_arbiter_if.slave  way1,
  output logic                rd_write_enable,
  output logic [4:0]          rd_addr,
  output logic [63:0]         rd_data,
`ifdef WB_DUAL_COMMIT_EN
  output logic                rd2_write_enable,
  output logic [4:0]          rd2_addr,
  output logic [63:0]         rd2_data,
  output logic [1:0]          commit_valid,
`else
  output logic                commit_valid,
`endif
  output logic [PID_W-1:0]    commit_pid,
  output logic                order_err,
  output logic                deadlock
);
  localparam int CW = $clog2(STALL_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STALL_LIMIT);
  wb_entry_t h0, h1, o;
  logic f0, f1, m0, m1, e0, e1, c0, c1, dual, go, stall, ow;
  logic [PID_W-1:0] exp_pid, step;
  logic [CW-1:0] cnt, cnt_nxt;
  wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk, .rst_n, .flush, .push(way0.valid), .pop(c0),
    .din({way0.we, way0.addr, way0.data, way0.pid}),
    .full(f0), .empty(m0), .head(h0)
  );
  wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk, .rst_n, .flush, .push(way1.valid), .pop(c1),
    .din({way1.we, way1.addr, way1.data, way1.pid}),
    .full(f1), .empty(m1), .head(h1)
  );
  assign way0.ready = !f0;
  assign way1.ready = !f1;
  assign e0 = !m0 && h0.pid == exp_pid;
  assign e1 = !m1 && h1.pid == exp_pid;
`ifdef WB_DUAL_COMMIT_EN
  wb_entry_t y;
  logic n0, n1, yw;
  assign n0 = !m0 && h0.pid == exp_pid + 1'b1;
  assign n1 = !m1 && h1.pid == exp_pid + 1'b1;
  assign dual = (e0 && n1) || (e1 && n0);
  assign y = e0 ? h1 : h0;
  assign yw = y.we && y.addr != '0;
`else
  assign dual = 1'b0;
`endif
  // way0 wins a tie; in a dual commit both ways pop
  assign c0 = e0 || dual;
  assign c1 = (e1 && !e0) || dual;
  assign o = e0 ? h0 : h1;
  assign go = (e0 || e1) && !flush;
  assign stall = !m0 && !m1 && !e0 && !e1;
  always_comb begin
    step = dual ? PID_W'(2) : PID_W'(1);
    cnt_nxt = (flush || go) ? '0 : (stall && cnt != LIM) ? cnt + 1'b1 : cnt;
`ifdef WB_DUAL_COMMIT_EN
    ow = o.we && o.addr != '0 && !(dual && yw && y.addr == o.addr);
`else
    ow = o.we && o.addr != '0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      exp_pid <= '0;
      cnt <= '0;
      rd_write_enable <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
      commit_valid <= '0;
      commit_pid <= '0;
      order_err <= 1'b0;
      deadlock <= 1'b0;
`ifdef WB_DUAL_COMMIT_EN
      rd2_write_enable <= 1'b0;
      rd2_addr <= '0;
      rd2_data <= '0;
`endif
    end else begin
      exp_pid <= flush ? flush_pid : go ? exp_pid + step : exp_pid;
      cnt <= cnt_nxt;
      order_err <= order_err || (e0 && e1 && !flush);
      deadlock <= deadlock || cnt_nxt == LIM;
      rd_write_enable <= go && ow;
      if (go) begin
        rd_addr <= o.addr;
        rd_data <= o.data;
        commit_pid <= o.pid;
      end
`ifdef WB_DUAL_COMMIT_EN
      commit_valid <= {go && dual, go};
      rd2_write_enable <= go && dual && yw;
      if (go && dual) begin
        rd2_addr <= y.addr;
        rd2_data <= y.data;
      end
`else
      commit_valid <= go;
`endif
    end
endmodule

// File: tb/tb_wb_commit_arbiter.sv
// tb_wb_commit_arbiter: directed scenarios plus random traffic against a queue-based retirement model.
module tb_wb_commit_arbiter;
  import b8_wb_pkg::*;
  localparam int DEPTH = 2;
  localparam int LIM = 15;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [PID_W-1:0] flush_pid = '0;
  logic rd_write_enable, commit_valid, order_err, deadlock;
  logic [4:0] rd_addr;
  logic [63:0] rd_data;
  logic [PID_W-1:0] commit_pid;
  int total = 0;
  int bad = 0;
  wb_commit_arbiter_if w0();
  wb_commit_arbiter_if w1();
  wb_entry_t q0[$], q1[$];
  logic m_we, m_cv, m_ord, m_dl;
  logic [4:0] m_addr;
  logic [63:0] m_data;
  logic [PID_W-1:0] m_pid, m_exp;
  int m_stall;
  always #5 clk = ~clk;
  wb_commit_arbiter #(.DEPTH(DEPTH), .STALL_LIMIT(LIM)) dut (
    .clk, .rst_n, .flush, .flush_pid, .way0(w0), .way1(w1),
    .rd_write_enable, .rd_addr, .rd_data, .commit_valid, .commit_pid,
    .order_err, .deadlock
  );
  task automatic reset_model();
    q0.delete();
    q1.delete();
    {m_we, m_cv, m_ord, m_dl, m_addr, m_data, m_pid, m_exp} = '0;
    m_stall = 0;
  endtask
  task automatic idle();
    w0.valid = 1'b0;
    w1.valid = 1'b0;
  endtask
  task automatic put(input bit way, input bit we, input logic [4:0] addr, input logic [63:0] data, input logic [PID_W-1:0] pid);
    if (way) begin
      w1.valid = 1'b1; w1.we = we; w1.addr = addr; w1.data = data; w1.pid = pid;
    end else begin
      w0.valid = 1'b1; w0.we = we; w0.addr = addr; w0.data = data; w0.pid = pid;
    end
  endtask
  // one clock: the model retires the oldest matching head, then appends accepted requests
  task automatic cyc();
    wb_entry_t a0, a1, ent;
    bit v0, v1, f, r0, r1, e0, e1;
    logic [PID_W-1:0] fp;
    v0 = w0.valid; v1 = w1.valid; f = flush; fp = flush_pid;
    a0 = '{w0.we, w0.addr, w0.data, w0.pid};
    a1 = '{w1.we, w1.addr, w1.data, w1.pid};
    r0 = q0.size() < DEPTH;
    r1 = q1.size() < DEPTH;
    @(posedge clk);
    m_we = 1'b0;
    m_cv = 1'b0;
    if (f) begin
      q0.delete();
      q1.delete();
      m_exp = fp;
      m_stall = 0;
    end else begin
      e0 = q0.size() != 0 && q0[0].pid == m_exp;
      e1 = q1.size() != 0 && q1[0].pid == m_exp;
      if (e0 && e1) m_ord = 1'b1;
      if (e0 || e1) begin
        if (e0) ent = q0.pop_front(); else ent = q1.pop_front();
        m_we = ent.we && ent.addr != 0;
        m_cv = 1'b1;
        m_addr = ent.addr;
        m_data = ent.data;
        m_pid = ent.pid;
        m_exp = m_exp + 1'b1;
        m_stall = 0;
      end else if (q0.size() != 0 && q1.size() != 0 && m_stall < LIM) m_stall++;
      if (m_stall == LIM) m_dl = 1'b1;
      if (v0 && r0) q0.push_back(a0);
      if (v1 && r1) q1.push_back(a1);
    end
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    {w0.we, w0.addr, w0.data, w0.pid} = '0;
    {w1.we, w1.addr, w1.data, w1.pid} = '0;
    reset_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if ({rd_write_enable, rd_addr, rd_data, commit_valid, commit_pid, order_err, deadlock} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got we=%b a=%0d d=%h cv=%b pid=%0d oe=%b dl=%b want all 0",
               rd_write_enable, rd_addr, rd_data, commit_valid, commit_pid, order_err, deadlock);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if ({w0.ready, w1.ready} !== 2'b11) begin
      bad++;
      $display("FAIL reset_ready got %b%b want 11", w0.ready, w1.ready);
    end
  endtask
  task automatic test_in_order();
    put(0, 1, 5, 64'hA, 0);
    put(1, 1, 6, 64'hB, 1);
    cyc();
    idle();
    total++;
    if (commit_valid !== 1'b0) begin bad++; $display("FAIL in_order_latency got cv=%b want 0", commit_valid); end
    cyc();
    total++;
    if ({commit_valid, rd_write_enable, rd_addr, rd_data, commit_pid} !== {1'b1, 1'b1, 5'd5, 64'hA, 2'd0}) begin
      bad++;
      $display("FAIL in_order_x5 got cv=%b we=%b a=%0d d=%h pid=%0d want 1 1 5 a 0", commit_valid, rd_write_enable, rd_addr, rd_data, commit_pid);
    end
    cyc();
    total++;
    if ({commit_valid, rd_write_enable, rd_addr, rd_data, commit_pid} !== {1'b1, 1'b1, 5'd6, 64'hB, 2'd1}) begin
      bad++;
      $display("FAIL in_order_x6 got cv=%b we=%b a=%0d d=%h pid=%0d want 1 1 6 b 1", commit_valid, rd_write_enable, rd_addr, rd_data, commit_pid);
    end
  endtask
  task automatic test_out_of_order();
    put(1, 1, 7, 64'h77, 3);
    cyc();
    idle();
    cyc();
    cyc();
    total++;
    if (commit_valid !== 1'b0) begin bad++; $display("FAIL ooo_wait got cv=%b want 0", commit_valid); end
    put(0, 1, 8, 64'h88, 2);
    cyc();
    idle();
    cyc();
    total++;
    if ({commit_valid, rd_addr, rd_data, commit_pid} !== {1'b1, 5'd8, 64'h88, 2'd2}) begin
      bad++;
      $display("FAIL ooo_x8 got cv=%b a=%0d d=%h pid=%0d want 1 8 88 2", commit_valid, rd_addr, rd_data, commit_pid);
    end
    cyc();
    total++;
    if ({commit_valid, rd_addr, rd_data, commit_pid, order_err, deadlock} !== {1'b1, 5'd7, 64'h77, 2'd3, 2'b00}) begin
      bad++;
      $display("FAIL ooo_x7 got cv=%b a=%0d d=%h pid=%0d oe=%b dl=%b want 1 7 77 3 0 0", commit_valid, rd_addr, rd_data, commit_pid, order_err, deadlock);
    end
  endtask
  task automatic test_back_pressure();
    int n;
    bit acc;
    n = 0;
    put(0, 1, 1, 64'h1, 1);
    cyc();
    put(0, 1, 2, 64'h2, 2);
    cyc();
    put(0, 1, 3, 64'h3, 3);
    total++;
    if (w0.ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got %b want 0", w0.ready); end
    put(1, 1, 4, 64'h0, 0);
    for (int i = 0; i < 10; i++) begin
      acc = w0.valid && w0.ready;
      cyc();
      if (acc) w0.valid = 1'b0;
      w1.valid = 1'b0;
      if (commit_valid === 1'b1) begin
        total++;
        if (commit_pid !== PID_W'(n)) begin bad++; $display("FAIL bp_order got pid=%0d want %0d", commit_pid, n); end
        n++;
      end
    end
    total++;
    if (n != 4) begin bad++; $display("FAIL bp_count got %0d commits want 4", n); end
  endtask
  task automatic test_x0();
    put(0, 1, 0, 64'h55, 0);
    cyc();
    idle();
    cyc();
    total++;
    if ({commit_valid, rd_write_enable, commit_pid} !== {1'b1, 1'b0, 2'd0}) begin
      bad++;
      $display("FAIL x0_nowrite got cv=%b we=%b pid=%0d want 1 0 0", commit_valid, rd_write_enable, commit_pid);
    end
    put(1, 1, 3, 64'h33, 1);
    cyc();
    idle();
    cyc();
    total++;
    if ({commit_valid, rd_write_enable, rd_addr, commit_pid} !== {1'b1, 1'b1, 5'd3, 2'd1}) begin
      bad++;
      $display("FAIL x0_advance got cv=%b we=%b a=%0d pid=%0d want 1 1 3 1", commit_valid, rd_write_enable, rd_addr, commit_pid);
    end
  endtask
  task automatic test_flush();
    flush = 1'b1;
    flush_pid = 0;
    cyc();
    flush = 1'b0;
    put(0, 1, 1, 64'h1, 2);
    put(1, 1, 2, 64'h2, 3);
    cyc();
    idle();
    cyc();
    total++;
    if (commit_valid !== 1'b0) begin bad++; $display("FAIL flush_hold got cv=%b want 0", commit_valid); end
    flush = 1'b1;
    flush_pid = 1;
    put(0, 1, 4, 64'h4, 1);
    cyc();
    flush = 1'b0;
    idle();
    total++;
    if ({commit_valid, rd_write_enable} !== 2'b00) begin bad++; $display("FAIL flush_strobe got cv=%b we=%b want 0 0", commit_valid, rd_write_enable); end
    cyc();
    total++;
    if ({commit_valid, w0.ready, w1.ready} !== 3'b011) begin
      bad++;
      $display("FAIL flush_empty got cv=%b rdy=%b%b want 0 11", commit_valid, w0.ready, w1.ready);
    end
    put(1, 1, 9, 64'h99, 1);
    cyc();
    idle();
    cyc();
    total++;
    if ({commit_valid, rd_addr, rd_data, commit_pid} !== {1'b1, 5'd9, 64'h99, 2'd1}) begin
      bad++;
      $display("FAIL flush_resume got cv=%b a=%0d d=%h pid=%0d want 1 9 99 1", commit_valid, rd_addr, rd_data, commit_pid);
    end
  endtask
  task automatic test_random();
    logic [PID_W-1:0] nxt;
    bit a0, a1;
    logic [76:0] got, want;
    nxt = m_exp;
    for (int i = 0; i < 400; i++) begin
      if (!w0.valid && $urandom_range(1, 0) == 1) begin
        put(0, 1'($urandom), 5'($urandom), {$urandom, $urandom}, ($urandom_range(15, 0) == 0) ? PID_W'($urandom) : nxt);
        nxt = nxt + 1'b1;
      end
      if (!w1.valid && $urandom_range(1, 0) == 1) begin
        put(1, 1'($urandom), 5'($urandom), {$urandom, $urandom}, ($urandom_range(15, 0) == 0) ? PID_W'($urandom) : nxt);
        nxt = nxt + 1'b1;
      end
      flush = ($urandom_range(31, 0) == 0);
      flush_pid = PID_W'($urandom);
      a0 = w0.valid && w0.ready;
      a1 = w1.valid && w1.ready;
      cyc();
      if (a0) w0.valid = 1'b0;
      if (a1) w1.valid = 1'b0;
      if (flush) begin
        nxt = flush_pid;
        idle();
        flush = 1'b0;
      end
      got = {commit_valid, rd_write_enable, rd_addr, rd_data, commit_pid, order_err, deadlock, w0.ready, w1.ready};
      want = {m_cv, m_we, m_addr, m_data, m_pid, m_ord, m_dl, 1'(q0.size() < DEPTH), 1'(q1.size() < DEPTH)};
      total++;
      if (got !== want) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", i, got, want); end
    end
  endtask
  task automatic test_faults();
    rst_n = 1'b0;
    idle();
    flush = 1'b0;
    reset_model();
    #2;
    rst_n = 1'b1;
    put(0, 1, 9, 64'h9, 0);
    put(1, 1, 10, 64'h10, 0);
    cyc();
    idle();
    cyc();
    total++;
    if ({commit_valid, rd_addr, order_err} !== {1'b1, 5'd9, 1'b1}) begin
      bad++;
      $display("FAIL fault_order got cv=%b a=%0d oe=%b want 1 9 1", commit_valid, rd_addr, order_err);
    end
    flush = 1'b1;
    flush_pid = 0;
    cyc();
    flush = 1'b0;
    total++;
    if (order_err !== 1'b1) begin bad++; $display("FAIL fault_sticky got oe=%b want 1", order_err); end
    put(0, 1, 1, 64'h1, 2);
    put(1, 1, 2, 64'h2, 3);
    cyc();
    idle();
    for (int i = 1; i <= LIM; i++) begin
      cyc();
      if (i == LIM - 1) begin
        total++;
        if (deadlock !== 1'b0) begin bad++; $display("FAIL deadlock_early got %b want 0 after %0d", deadlock, i); end
      end
      if (i == LIM) begin
        total++;
        if (deadlock !== 1'b1) begin bad++; $display("FAIL deadlock_set got %b want 1 after %0d", deadlock, i); end
      end
    end
  endtask
  task automatic test_reset_sticky();
    rst_n = 1'b0;
    reset_model();
    #1;
    total++;
    if ({order_err, deadlock, commit_valid} !== 3'b000) begin
      bad++;
      $display("FAIL async_reset_flags got oe=%b dl=%b cv=%b want 0 0 0", order_err, deadlock, commit_valid);
    end
    rst_n = 1'b1;
  endtask
  initial begin
    test_reset();
    test_in_order();
    test_out_of_order();
    test_back_pressure();
    test_x0();
    test_flush();
    test_random();
    test_faults();
    test_reset_sticky();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
